// File: rtl/rf_read_fwd_pkg.sv
// Shared constants and helpers for the register file / operand read block.
// Holds the WB_* write-back select encoding used here and by the WB selector.
package rf_read_fwd_pkg;

    localparam logic [2:0] WB_ALU = 3'b001;
    localparam logic [2:0] WB_RS  = 3'b010;
    localparam logic [2:0] WB_RAM = 3'b011;
    localparam logic [2:0] WB_HI  = 3'b100;
    localparam logic [2:0] WB_LO  = 3'b101;
    localparam logic [2:0] WB_PC8 = 3'b110;
    localparam logic [2:0] WB_CP0 = 3'b111;

    // Selects whose result does not exist yet while the producer is in EX.
    function automatic logic is_late_sel(input logic [2:0] wsel);
        return (wsel == WB_RAM) || (wsel == WB_CP0);
    endfunction

    // A producer matches a read when it writes, targets it, and it is not $0.
    function automatic logic src_hit(
        input logic       nwe,
        input logic [4:0] waddr,
        input logic [4:0] raddr
    );
        return nwe && (waddr == raddr) && (raddr != 5'd0);
    endfunction

endpackage

// File: rtl/rf_read_fwd_if.sv
// ID-stage operand read bus: two read addresses with use flags in,
// forwarded operand data and the load-use stall out.
interface rf_read_fwd_if;

    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_used;
    logic        rt_used;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        load_use_stall;

    // ID stage drives the request side.
    modport master (
        output rs_addr, rt_addr, rs_used, rt_used,
        input  rs_data, rt_data, load_use_stall
    );

    // Register file block answers it.
    modport slave (
        input  rs_addr, rt_addr, rs_used, rt_used,
        output rs_data, rt_data, load_use_stall
    );

endinterface

// File: rtl/rf_read_fwd_array.sv
// rf_array: 31x32 GPR storage with one write port and two async read ports.
// Ports: clk, rst_n, we/waddr/wdata write port, raddr_a/b -> rdata_a/b.
module rf_array (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    // $0 has no storage; it is hardwired to zero on the read side.
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs_q[raddr_b];

endmodule

// File: rtl/rf_read_fwd.sv
// rf_read_fwd: GPR file plus ID operand forwarding, load-use stall detect
// and a saturating stall-cycle counter. Ports: clk, rst_n, rd (read bus),
// EX/MEM producer taps, WB write port, stall_cnt.
module rf_read_fwd
    import rf_read_fwd_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    rf_read_fwd_if.slave rd,
    input  logic         ex_rf_nwe,
    input  logic [4:0]   ex_waddr,
    input  logic [2:0]   ex_wsel,
    input  logic [31:0]  ex_fwd_data,
    input  logic         mem_rf_nwe,
    input  logic [4:0]   mem_waddr,
    input  logic [31:0]  mem_fwd_data,
    input  logic         rf_nwe,
    input  logic [4:0]   rf_waddr,
    input  logic [31:0]  rf_wdata,
    output logic [31:0]  stall_cnt
);

    logic [31:0] rs_arr;
    logic [31:0] rt_arr;

    rf_array u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_nwe),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rd.rs_addr),
        .raddr_b (rd.rt_addr),
        .rdata_a (rs_arr),
        .rdata_b (rt_arr)
    );

    logic ex_late;
    logic rs_ex, rs_mem, rs_wb;
    logic rt_ex, rt_mem, rt_wb;
    logic rs_stall, rt_stall, stall;

    always_comb begin
        ex_late = is_late_sel(ex_wsel);

        rs_ex  = src_hit(ex_rf_nwe, ex_waddr, rd.rs_addr);
        rs_mem = src_hit(mem_rf_nwe, mem_waddr, rd.rs_addr);
        rs_wb  = src_hit(rf_nwe, rf_waddr, rd.rs_addr);
        rt_ex  = src_hit(ex_rf_nwe, ex_waddr, rd.rt_addr);
        rt_mem = src_hit(mem_rf_nwe, mem_waddr, rd.rt_addr);
        rt_wb  = src_hit(rf_nwe, rf_waddr, rd.rt_addr);

        // A late EX producer is never forwarded; the stall covers it and
        // the operand falls through to older sources as don't-care.
        if (rs_ex && !ex_late)  rd.rs_data = ex_fwd_data;
        else if (rs_mem)        rd.rs_data = mem_fwd_data;
        else if (rs_wb)         rd.rs_data = rf_wdata;
        else                    rd.rs_data = rs_arr;

        if (rt_ex && !ex_late)  rd.rt_data = ex_fwd_data;
        else if (rt_mem)        rd.rt_data = mem_fwd_data;
        else if (rt_wb)         rd.rt_data = rf_wdata;
        else                    rd.rt_data = rt_arr;

        rs_stall = rd.rs_used && rs_ex && ex_late;
        rt_stall = rd.rt_used && rt_ex && ex_late;
        stall    = rs_stall || rt_stall;
        rd.load_use_stall = stall;
    end

    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_read_fwd.sv
// Directed bench for rf_read_fwd: reset, $0, WB bypass, priority,
// load-use and CP0 stalls, flushed writes and counter saturation.
module tb_rf_read_fwd;
    import rf_read_fwd_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        ex_rf_nwe;
    logic [4:0]  ex_waddr;
    logic [2:0]  ex_wsel;
    logic [31:0] ex_fwd_data;
    logic        mem_rf_nwe;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_fwd_data;
    logic        rf_nwe;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] stall_cnt;

    int n_chk;
    int n_fail;

    rf_read_fwd_if rd_if ();

    rf_read_fwd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd           (rd_if),
        .ex_rf_nwe    (ex_rf_nwe),
        .ex_waddr     (ex_waddr),
        .ex_wsel      (ex_wsel),
        .ex_fwd_data  (ex_fwd_data),
        .mem_rf_nwe   (mem_rf_nwe),
        .mem_waddr    (mem_waddr),
        .mem_fwd_data (mem_fwd_data),
        .rf_nwe       (rf_nwe),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        ex_rf_nwe     = 1'b0;
        ex_waddr      = 5'd0;
        ex_wsel       = WB_ALU;
        ex_fwd_data   = 32'd0;
        mem_rf_nwe    = 1'b0;
        mem_waddr     = 5'd0;
        mem_fwd_data  = 32'd0;
        rf_nwe        = 1'b0;
        rf_waddr      = 5'd0;
        rf_wdata      = 32'd0;
        rd_if.rs_addr = 5'd0;
        rd_if.rt_addr = 5'd0;
        rd_if.rs_used = 1'b0;
        rd_if.rt_used = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        // Write $4 and take one stall edge so there is state to clear.
        rf_nwe = 1'b1; rf_waddr = 5'd4; rf_wdata = 32'h55;
        ex_rf_nwe = 1'b1; ex_waddr = 5'd4; ex_wsel = WB_RAM;
        rd_if.rs_addr = 5'd4; rd_if.rs_used = 1'b1;
        @(negedge clk);
        idle();
        rd_if.rs_addr = 5'd4;
        #1;
        n_chk++;
        if (stall_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL pre_reset_cnt got %h want %h", stall_cnt, 32'd1);
        end
        n_chk++;
        if (rd_if.rs_data !== 32'h55) begin
            n_fail++;
            $display("FAIL pre_reset_r4 got %h want %h", rd_if.rs_data, 32'h55);
        end
        // Write to $6 in flight when reset hits mid-cycle.
        rf_nwe = 1'b1; rf_waddr = 5'd6; rf_wdata = 32'h66;
        #1;
        rst_n = 1'b0;
        #1;
        rf_nwe = 1'b0;
        rd_if.rt_addr = 5'd6;
        #1;
        n_chk++;
        if (rd_if.rs_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_r4 got %h want %h", rd_if.rs_data, 32'd0);
        end
        n_chk++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt got %h want %h", stall_cnt, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_chk++;
        if (rd_if.rt_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_lost_write got %h want %h", rd_if.rt_data, 32'd0);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle();
        rf_nwe = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'hDEADBEEF;
        ex_rf_nwe = 1'b1; ex_waddr = 5'd0; ex_wsel = WB_RAM;
        ex_fwd_data = 32'hFACE;
        rd_if.rs_addr = 5'd0; rd_if.rs_used = 1'b1;
        #1;
        n_chk++;
        if (rd_if.rs_data !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_bypass got %h want %h", rd_if.rs_data, 32'd0);
        end
        n_chk++;
        if (rd_if.load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_stall got %b want %b", rd_if.load_use_stall, 1'b0);
        end
        @(negedge clk);
        idle();
        #1;
        n_chk++;
        if (rd_if.rs_data !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_array got %h want %h", rd_if.rs_data, 32'd0);
        end
    endtask

    task automatic test_wb_through();
        @(negedge clk);
        idle();
        rf_nwe = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'h1234_5678;
        rd_if.rs_addr = 5'd5;
        #1;
        n_chk++;
        if (rd_if.rs_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wb_bypass got %h want %h", rd_if.rs_data, 32'h1234_5678);
        end
        @(negedge clk);
        rf_nwe = 1'b0; rf_wdata = 32'h0;
        #1;
        n_chk++;
        if (rd_if.rs_data !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL wb_array got %h want %h", rd_if.rs_data, 32'h1234_5678);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        idle();
        ex_rf_nwe = 1'b1; ex_waddr = 5'd7; ex_wsel = WB_ALU; ex_fwd_data = 32'hA;
        mem_rf_nwe = 1'b1; mem_waddr = 5'd7; mem_fwd_data = 32'hB;
        rf_nwe = 1'b1; rf_waddr = 5'd7; rf_wdata = 32'hC;
        rd_if.rt_addr = 5'd7; rd_if.rt_used = 1'b1;
        #1;
        n_chk++;
        if (rd_if.rt_data !== 32'hA) begin
            n_fail++;
            $display("FAIL prio_ex got %h want %h", rd_if.rt_data, 32'hA);
        end
        n_chk++;
        if (rd_if.load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_alu_stall got %b want %b", rd_if.load_use_stall, 1'b0);
        end
        ex_rf_nwe = 1'b0;
        #1;
        n_chk++;
        if (rd_if.rt_data !== 32'hB) begin
            n_fail++;
            $display("FAIL prio_mem got %h want %h", rd_if.rt_data, 32'hB);
        end
        mem_rf_nwe = 1'b0;
        #1;
        n_chk++;
        if (rd_if.rt_data !== 32'hC) begin
            n_fail++;
            $display("FAIL prio_wb got %h want %h", rd_if.rt_data, 32'hC);
        end
        rf_nwe = 1'b0;
        #1;
        n_chk++;
        if (rd_if.rt_data !== 32'd0) begin
            n_fail++;
            $display("FAIL prio_array got %h want %h", rd_if.rt_data, 32'd0);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        idle();
        ex_rf_nwe = 1'b1; ex_waddr = 5'd9; ex_wsel = WB_RAM;
        rd_if.rs_addr = 5'd9; rd_if.rs_used = 1'b1;
        #1;
        n_chk++;
        if (rd_if.load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall got %b want %b", rd_if.load_use_stall, 1'b1);
        end
        @(negedge clk);
        rd_if.rs_used = 1'b0;
        #1;
        n_chk++;
        if (stall_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL lu_cnt got %h want %h", stall_cnt, 32'd1);
        end
        n_chk++;
        if (rd_if.load_use_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_unused got %b want %b", rd_if.load_use_stall, 1'b0);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (stall_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL lu_cnt_hold got %h want %h", stall_cnt, 32'd1);
        end
    endtask

    task automatic test_cp0_flush();
        @(negedge clk);
        idle();
        rf_nwe = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h33;
        @(negedge clk);
        idle();
        ex_rf_nwe = 1'b1; ex_waddr = 5'd3; ex_wsel = WB_CP0;
        mem_rf_nwe = 1'b1; mem_waddr = 5'd3; mem_fwd_data = 32'hBB;
        rf_nwe = 1'b0; rf_waddr = 5'd3; rf_wdata = 32'hFFFF;
        rd_if.rs_addr = 5'd1; rd_if.rs_used = 1'b1;
        rd_if.rt_addr = 5'd3; rd_if.rt_used = 1'b1;
        #1;
        n_chk++;
        if (rd_if.load_use_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL cp0_stall got %b want %b", rd_if.load_use_stall, 1'b1);
        end
        @(negedge clk);
        ex_rf_nwe = 1'b0; mem_rf_nwe = 1'b0;
        #1;
        n_chk++;
        if (stall_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL cp0_cnt got %h want %h", stall_cnt, 32'd2);
        end
        n_chk++;
        if (rd_if.rt_data !== 32'h33) begin
            n_fail++;
            $display("FAIL flushed_wb got %h want %h", rd_if.rt_data, 32'h33);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        idle();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        ex_rf_nwe = 1'b1; ex_waddr = 5'd12; ex_wsel = WB_RAM;
        rd_if.rt_addr = 5'd12; rd_if.rt_used = 1'b1;
        #1;
        n_chk++;
        if (stall_cnt !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL sat_preset got %h want %h", stall_cnt, 32'hFFFF_FFFE);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_chk++;
            if (stall_cnt !== 32'hFFFF_FFFF) begin
                n_fail++;
                $display("FAIL sat_cyc%0d got %h want %h", i, stall_cnt, 32'hFFFF_FFFF);
            end
        end
        idle();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        test_reset();
        test_zero_reg();
        test_wb_through();
        test_priority();
        test_load_use();
        test_cp0_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_read_fwd.md
# rf_read_fwd

Register-file and operand-read block for the 5-stage MIPS pipeline. Owns the 31 architectural GPRs and $0. Takes the final write-back port (`rf_waddr`/`rf_wdata`/`rf_nwe`) and serves the two ID-stage read ports. Resolves RAW hazards by forwarding from the EX and MEM producers, raises a load-use stall when the producer's data does not exist yet, and counts stall cycles for performance monitoring.

## Interface
- No parameters; widths are fixed (32 registers × 32 bit).
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- rs_addr, rt_addr  in  5 each  ID-stage read addresses.
- rs_used, rt_used  in  1 each  ID instruction actually reads that operand.
- ex_rf_nwe  in  1  EX instruction writes the register file (high = write).
- ex_waddr  in  5  EX destination register.
- ex_wsel  in  3  EX write-back select (WB_* encoding).
- ex_fwd_data  in  32  EX result value.
- mem_rf_nwe  in  1  MEM instruction writes the register file.
- mem_waddr  in  5  MEM destination register.
- mem_fwd_data  in  32  MEM final write-back value, all selects.
- rf_nwe  in  1  WB write strobe, already gated by exception/interrupt flush.
- rf_waddr  in  5  WB destination register.
- rf_wdata  in  32  WB data.
- rs_data, rt_data  out  32 each  forwarded operands.
- load_use_stall  out  1  freeze PC/IF/ID and bubble EX.
- stall_cnt  out  32  stall cycles since reset.

## Operation
- Array update: on posedge clk, if `rf_nwe` and `rf_waddr != 0`, write `rf_wdata` to the array. Writes to $0 are discarded.
- Read of address 0 always returns 0. It never forwards and never stalls.
- Operand priority, highest first:
  - EX match: `ex_rf_nwe`, `ex_waddr == addr`, `ex_wsel` not WB_RAM/WB_CP0 → `ex_fwd_data`.
  - MEM match: `mem_rf_nwe`, `mem_waddr == addr` → `mem_fwd_data`.
  - WB match: `rf_nwe`, `rf_waddr == addr` → `rf_wdata` (same-cycle write-through).
  - Otherwise → array contents.
- Load-use stall: asserted when an operand is used, the EX stage writes it (nonzero address), and `ex_wsel` is WB_RAM or WB_CP0. The EX value is not forwarded in that case; operand data is don't-care.
- `load_use_stall` is evaluated separately for rs and rt and the two results are ORed.
- stall_cnt: increments by 1 on each clock edge where `load_use_stall` is high. It saturates at 0xFFFF_FFFF and does not wrap.

## Timing
- Reads, forwarding and stall are combinational from inputs to outputs within the same cycle. The array and the counter are the only state.
- Write latency: data is visible in the array one edge after the write. The WB bypass covers the write cycle itself.
- Reset: asynchronous. All registers and `stall_cnt` go to 0 immediately. Outputs then read 0 unless a forwarding source is active.
- Reset mid-write: the write is lost; the register reads 0.
- Simultaneous EX/MEM/WB to the same register: EX wins, then MEM, then WB.
- Stall with the same register in EX (load) and in MEM: stall is still asserted. The older MEM value is not used.
- A flushed WB write (`rf_nwe` = 0) neither updates the array nor bypasses.

## Structure
- A shared package holds the WB_* constants: ALU=001, RS=010, RAM=011, HI=100, LO=101, PC8=110, CP0=111. This block and the write-back selector both use it.
- Sub-module `rf_array` contains the 31×32 storage, its write port, and async-reset clear.
- The top level contains:
  - forwarding priority muxes;
  - stall logic;
  - the saturating counter.

## Test plan
- Reset and $0:
  - Assert rst_n=0 mid-cycle → all reads return 0 and stall_cnt = 0.
  - Write $0 = 0xDEADBEEF → read $0 = 0.
- WB write-through:
  - Write $5 = 0x1234_5678 and read $5 in the same cycle → rs_data = 0x1234_5678.
  - Next cycle, with no write active → still 0x1234_5678 from the array.
- Priority:
  - Set EX $7 = 0xA, MEM $7 = 0xB, WB $7 = 0xC.
  - Read rt=$7 → 0xA.
  - Drop EX → 0xB.
  - Drop MEM → 0xC.
- Load-use:
  - EX has wsel=011 and dest $9; ID has rs=$9 with rs_used=1 → load_use_stall = 1, and stall_cnt goes 0→1.
  - Same setup with rs_used=0 → no stall.
- CP0 stall and flushed write:
  - EX has wsel=111 and dest $3; ID reads rt=$3 → stall.
  - WB has rf_nwe=0 with rf_waddr=$3 → array is unchanged.
- Counter saturation:
  - Force stall_cnt = 0xFFFF_FFFE and hold the stall for 3 cycles → stall_cnt = 0xFFFF_FFFF and stays there.
